mul_seq: RTL and testbench

Multi-cycle unsigned multiplier controller that sequences a single instance of the team's `alu` block (add/sub/and/or, `ControlloALU` 2-bit select, `Carry` flag). It implements N-step shift-and-add, computing a 2N-bit product in N cycles. It sits beside the single-cycle datapath as a long-latency functional unit with valid/ready handshakes on both sides. Only ALU operation 00 (add, carry-in 0) is used.

---
 rtl/mul_seq_pkg.sv | 15 +
 rtl/alu.sv | 42 ++++
 rtl/mul_seq.sv | 100 ++++++++++
 tb/tb_mul_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for sequencers built around the team alu block.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/alu.sv
// Team N-bit ALU: add/sub/and/or selected by ControlloALU, with NZCV flags.
module alu
    import mul_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [1:0]   ControlloALU,
    output logic [N-1:0] Result,
    output logic         Negative,
    output logic         Zero,
    output logic         Carry,
    output logic         oVerflow
);

    logic [N:0] wide;

    always_comb begin
        wide     = '0;
        oVerflow = 1'b0;
        case (ControlloALU)
            ALU_ADD: begin
                wide     = {1'b0, A} + {1'b0, B};
                oVerflow = (A[N-1] == B[N-1]) && (wide[N-1] != A[N-1]);
            end
            ALU_SUB: begin
                // Carry set means no borrow, as in A + ~B + 1.
                wide     = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, 1'b1};
                oVerflow = (A[N-1] != B[N-1]) && (wide[N-1] != A[N-1]);
            end
            ALU_AND: wide = {1'b0, A & B};
            default: wide = {1'b0, A | B};
        endcase
    end

    assign Result   = wide[N-1:0];
    assign Carry    = wide[N];
    assign Negative = wide[N-1];
    assign Zero     = (wide[N-1:0] == '0);

endmodule

// File: rtl/mul_seq.sv
// Shift-and-add unsigned multiplier: one alu add per cycle, 2N-bit product in N cycles.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   op_a,
    input  logic [N-1:0]   op_b,
    input  logic           abort,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           prod_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t        state;
    logic [N-1:0]  m;
    logic [N-1:0]  p_hi;
    logic [N-1:0]  p_lo;
    logic [CW-1:0] cnt;

    logic [N-1:0]  alu_b;
    logic [N-1:0]  sum;
    logic          carry;

    assign alu_b = p_lo[0] ? m : '0;

    alu #(.N(N)) u_alu (
        .A            (p_hi),
        .B            (alu_b),
        .ControlloALU (ALU_ADD),
        .Result       (sum),
        .Negative     (),
        .Zero         (),
        .Carry        (carry),
        .oVerflow     ()
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            m         <= '0;
            p_hi      <= '0;
            p_lo      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // abort is deliberately not looked at here.
                    if (in_valid) begin
                        m        <= op_a;
                        p_lo     <= op_b;
                        p_hi     <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        // Carry lands in the top bit so the partial sum never overflows.
                        {p_hi, p_lo} <= {carry, sum, p_lo[N-1:1]};
                        cnt          <= cnt + CW'(1);
                        if (cnt == CW'(N-1)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (abort || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign product   = {p_hi, p_lo};
    assign prod_zero = (product == '0);

endmodule

// File: tb/tb_mul_seq.sv
// Directed-vector bench for mul_seq at N=32 with hand-computed products.
module tb_mul_seq;

    localparam int N = 32;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic           abort;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           prod_zero;

    int n_checks = 0;
    int n_fail   = 0;

    mul_seq #(.N(N)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .prod_zero (prod_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits for in_ready, offers a/b, and leaves time at acceptance edge + 1.
    task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            tick();
            w++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < N + 8) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(N));
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [63:0] exp, input logic exp_zero);
        int cyc;
        out_ready = 1'b1;
        accept(a, b);
        wait_done(tag, cyc);
        check({tag, "_product"}, product, exp);
        check({tag, "_prod_zero"}, 64'(prod_zero), 64'(exp_zero));
        tick();
        check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int cyc;
        int bad;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_prod_zero", 64'(prod_zero), 64'd1);
        reset_n = 1'b1;
        tick();

        run_op("mul_3x5", 32'd3, 32'd5, 64'd15, 1'b0);
        run_op("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
        run_op("mul_zero", 32'h0, 32'h12345678, 64'h0, 1'b1);
        run_op("mul_msb", 32'h80000000, 32'd2, 64'h1_00000000, 1'b0);

        // Backpressure with a competing operand pair offered throughout.
        out_ready = 1'b0;
        accept(32'd100, 32'd200);
        op_a     = 32'd7;
        op_b     = 32'd7;
        in_valid = 1'b1;
        tick();
        check("bp_in_ready_run", 64'(in_ready), 64'd0);
        cyc = 1;
        while (!out_valid && cyc < N + 8) begin
            tick();
            cyc++;
        end
        check("bp_latency", 64'(cyc), 64'(N));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_product", product, 64'd20000);
            check("bp_in_ready_done", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);

        // Abort raised for the edge of RUN step 7.
        accept(32'd11, 32'd13);
        for (int i = 0; i < 6; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        bad = 0;
        for (int i = 0; i < N + 4; i++) begin
            tick();
            if (out_valid) bad++;
        end
        check("abort_no_valid", 64'(bad), 64'd0);
        run_op("mul_7x6", 32'd7, 32'd6, 64'd42, 1'b0);

        // Asynchronous reset between edges in the middle of RUN.
        accept(32'h55, 32'h77);
        for (int i = 0; i < 10; i++) tick();
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_product", product, 64'd0);
        check("arst_prod_zero", 64'(prod_zero), 64'd1);
        tick();
        tick();
        #2;
        reset_n = 1'b1;
        tick();
        run_op("mul_9x9", 32'd9, 32'd9, 64'd81, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
